pe_vec_mac: RTL

//  Next-generation systolic PE: buffers W/I/O streams, forwards W and I to neighbour PEs, runs a fixed-latency MAC.

---
 rtl/pe_pkg.sv | 22 ++
 rtl/pe_sync_fifo.sv | 66 ++++++
 rtl/pe_vec_mac.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/pe_pkg.sv
// Package pe_pkg
// Shared types and helpers for the pe_vec_mac processing element.
//   pe_mode_t     : runtime MAC mode (CHAIN psum chaining / LOCAL output-stationary)
//   PE_ACC_LEN_W  : default width of the LOCAL accumulation-length config
//   pe_clog2      : ceil(log2(value)) for sizing pointers and counters
package pe_pkg;

  typedef enum logic {
    PE_MODE_CHAIN = 1'b0,
    PE_MODE_LOCAL = 1'b1
  } pe_mode_t;

  localparam int PE_ACC_LEN_W = 16;

  function automatic int pe_clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/pe_sync_fifo.sv
// Module pe_sync_fifo
// Synchronous first-word-fall-through FIFO used for the W/I/O input queues and
// the result queue of pe_vec_mac.
// Ports:
//   clk, aclr (async, active-low), clk_en (0 freezes all state)
//   push/din    : write request; ignored while full
//   pop         : read request; ignored while empty
//   dout        : head word, valid whenever empty=0 (driven 0 when empty)
//   full, empty : status
//   count       : number of stored words
module pe_sync_fifo
  import pe_pkg::*;
#(
  parameter int DataWidth = 32,
  parameter int Depth     = 16,
  localparam int AW       = pe_clog2(Depth)
) (
  input  logic                 clk,
  input  logic                 aclr,
  input  logic                 clk_en,
  input  logic                 push,
  input  logic [DataWidth-1:0] din,
  input  logic                 pop,
  output logic [DataWidth-1:0] dout,
  output logic                 full,
  output logic                 empty,
  output logic [AW:0]          count
);

  logic [DataWidth-1:0] r_mem [Depth];
  logic [AW-1:0]        r_wr_ptr;
  logic [AW-1:0]        r_rd_ptr;
  logic [AW:0]          r_count;
  logic                 w_do_push;
  logic                 w_do_pop;

  // Full/empty come from the pre-edge count, so a pop on a full FIFO frees a
  // slot without letting a same-cycle push through.
  assign full      = (r_count == (AW + 1)'(Depth));
  assign empty     = (r_count == '0);
  assign count     = r_count;
  assign w_do_push = clk_en & push & ~full;
  assign w_do_pop  = clk_en & pop & ~empty;
  assign dout      = empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/pe_vec_mac.sv
// Module pe_vec_mac
// Systolic PE: queues W/I/O streams, forwards W and I to neighbours through
// registered forward ports, and runs a fixed-latency MAC pipeline.
//   CHAIN mode : result = W*I + O_in for every issue
//   LOCAL mode : accumulate acc_len products, emit one sum
// A credit check (result FIFO occupancy + in-flight ops < OutDepth) stops
// issue before the result FIFO could overflow, so the pipeline never stalls.
// Build option: define PE_SATURATE_EN to make the CHAIN add and the LOCAL
// accumulate saturate instead of wrap (the product is always truncated).
// Ports:
//   clk, aclr (async, active-low), clk_en (0 freezes all state)
//   cfg_mode, cfg_acc_len : shadowed only while busy=0
//   W_/I_/O_DataIn*       : input streams (valid/ready)
//   W_/I_DataOut*         : forward streams (registered)
//   O_DataOut*            : result stream (FWFT FIFO head)
//   busy                  : any queue, pipeline or LOCAL group in progress
module pe_vec_mac
  import pe_pkg::*;
#(
  parameter int DataWidth   = 32,
  parameter int InDepth     = 16,
  parameter int OutDepth    = 16,
  parameter int MacLatency  = 12,
  parameter int AccLenWidth = PE_ACC_LEN_W
) (
  input  logic                   clk,
  input  logic                   aclr,
  input  logic                   clk_en,
  input  logic                   cfg_mode,
  input  logic [AccLenWidth-1:0] cfg_acc_len,
  input  logic [DataWidth-1:0]   W_DataIn,
  input  logic                   W_DataInValid,
  output logic                   W_DataInRdy,
  output logic [DataWidth-1:0]   W_DataOut,
  output logic                   W_DataOutValid,
  input  logic                   W_DataOutRdy,
  input  logic [DataWidth-1:0]   I_DataIn,
  input  logic                   I_DataInValid,
  output logic                   I_DataInRdy,
  output logic [DataWidth-1:0]   I_DataOut,
  output logic                   I_DataOutValid,
  input  logic                   I_DataOutRdy,
  input  logic [DataWidth-1:0]   O_DataIn,
  input  logic                   O_DataInValid,
  output logic                   O_DataInRdy,
  output logic [DataWidth-1:0]   O_DataOut,
  output logic                   O_DataOutValid,
  input  logic                   O_DataOutRdy,
  output logic                   busy
);

  localparam int InCntW  = pe_clog2(InDepth) + 1;
  localparam int OutCntW = pe_clog2(OutDepth) + 1;
  localparam int FlyW    = pe_clog2(MacLatency + 1) + 1;

  logic [DataWidth-1:0]   w_w_dout, w_i_dout, w_o_dout, w_out_dout, w_out_din;
  logic                   w_w_full, w_i_full, w_o_full, w_out_full;
  logic                   w_w_empty, w_i_empty, w_o_empty, w_out_empty;
  logic [InCntW-1:0]      w_w_count, w_i_count, w_o_count;
  logic [OutCntW-1:0]     w_out_count;
  logic                   w_w_slot, w_i_slot, w_credit_ok, w_fire, w_pop_o;
  logic                   w_exit, w_last, w_out_push, w_out_pop;
  logic [DataWidth-1:0]   w_prod, w_stage0, w_exit_data, w_acc_sum;

  pe_mode_t               r_mode;
  logic [AccLenWidth-1:0] r_acc_len;
  logic [DataWidth-1:0]   r_w_fwd, r_i_fwd;
  logic                   r_w_fwd_vld, r_i_fwd_vld;
  logic [MacLatency-1:0]  r_pipe_vld;
  logic [DataWidth-1:0]   r_pipe_data [MacLatency];
  logic [FlyW-1:0]        r_inflight;
  logic [DataWidth-1:0]   r_acc;
  logic [AccLenWidth-1:0] r_lcount;

  function automatic logic [DataWidth-1:0] pe_add(input logic [DataWidth-1:0] a,
                                                   input logic [DataWidth-1:0] b);
    logic [DataWidth-1:0] s;
    s = a + b;
`ifdef PE_SATURATE_EN
    // Overflow only when both operands share a sign the sum does not.
    if ((a[DataWidth-1] == b[DataWidth-1]) && (s[DataWidth-1] != a[DataWidth-1]))
      s = a[DataWidth-1] ? {1'b1, {(DataWidth-1){1'b0}}} : {1'b0, {(DataWidth-1){1'b1}}};
`endif
    return s;
  endfunction

  pe_sync_fifo #(.DataWidth(DataWidth), .Depth(InDepth)) u_w_fifo (
    .clk(clk), .aclr(aclr), .clk_en(clk_en),
    .push(W_DataInValid), .din(W_DataIn), .pop(w_fire),
    .dout(w_w_dout), .full(w_w_full), .empty(w_w_empty), .count(w_w_count)
  );

  pe_sync_fifo #(.DataWidth(DataWidth), .Depth(InDepth)) u_i_fifo (
    .clk(clk), .aclr(aclr), .clk_en(clk_en),
    .push(I_DataInValid), .din(I_DataIn), .pop(w_fire),
    .dout(w_i_dout), .full(w_i_full), .empty(w_i_empty), .count(w_i_count)
  );

  pe_sync_fifo #(.DataWidth(DataWidth), .Depth(InDepth)) u_o_fifo (
    .clk(clk), .aclr(aclr), .clk_en(clk_en),
    .push(O_DataInValid), .din(O_DataIn), .pop(w_pop_o),
    .dout(w_o_dout), .full(w_o_full), .empty(w_o_empty), .count(w_o_count)
  );

  pe_sync_fifo #(.DataWidth(DataWidth), .Depth(OutDepth)) u_out_fifo (
    .clk(clk), .aclr(aclr), .clk_en(clk_en),
    .push(w_out_push), .din(w_out_din), .pop(w_out_pop),
    .dout(w_out_dout), .full(w_out_full), .empty(w_out_empty), .count(w_out_count)
  );

  assign W_DataInRdy    = ~w_w_full;
  assign I_DataInRdy    = ~w_i_full;
  assign O_DataInRdy    = ~w_o_full;
  assign W_DataOut      = r_w_fwd;
  assign W_DataOutValid = r_w_fwd_vld;
  assign I_DataOut      = r_i_fwd;
  assign I_DataOutValid = r_i_fwd_vld;
  assign O_DataOut      = w_out_dout;
  assign O_DataOutValid = ~w_out_empty;
  assign w_out_pop      = O_DataOutRdy;

  assign busy = (w_w_count != '0) | (w_i_count != '0) | (w_o_count != '0) |
                (w_out_count != '0) | (r_inflight != '0) | (r_lcount != '0);

  // Issue
  assign w_w_slot    = ~r_w_fwd_vld | W_DataOutRdy;
  assign w_i_slot    = ~r_i_fwd_vld | I_DataOutRdy;
  // In LOCAL mode this reserves one slot per product even though only one in
  // acc_len of them becomes a result; simple and always safe.
  assign w_credit_ok = (32'(w_out_count) + 32'(r_inflight)) < 32'(OutDepth);
  assign w_fire      = clk_en & ~w_w_empty & ~w_i_empty &
                       ((r_mode == PE_MODE_LOCAL) | ~w_o_empty) &
                       w_w_slot & w_i_slot & w_credit_ok;
  assign w_pop_o     = w_fire & (r_mode == PE_MODE_CHAIN);

  // The chain add is folded into stage 0; the remaining stages only delay.
  assign w_prod   = w_w_dout * w_i_dout;
  assign w_stage0 = (r_mode == PE_MODE_CHAIN) ? pe_add(w_prod, w_o_dout) : w_prod;

  assign w_exit      = clk_en & r_pipe_vld[MacLatency-1];
  assign w_exit_data = r_pipe_data[MacLatency-1];
  assign w_last      = (r_lcount == (r_acc_len - AccLenWidth'(1)));
  assign w_acc_sum   = pe_add(r_acc, w_exit_data);
  assign w_out_push  = w_exit & ((r_mode == PE_MODE_CHAIN) | w_last) & ~w_out_full;
  assign w_out_din   = (r_mode == PE_MODE_CHAIN) ? w_exit_data : w_acc_sum;

  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      r_mode    <= PE_MODE_CHAIN;
      r_acc_len <= AccLenWidth'(1);
    end else if (clk_en && !busy) begin
      r_mode    <= pe_mode_t'(cfg_mode);
      r_acc_len <= (cfg_acc_len == '0) ? AccLenWidth'(1) : cfg_acc_len;
    end
  end

  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      r_w_fwd     <= '0;
      r_i_fwd     <= '0;
      r_w_fwd_vld <= 1'b0;
      r_i_fwd_vld <= 1'b0;
    end else if (clk_en) begin
      if (w_fire) begin
        r_w_fwd     <= w_w_dout;
        r_i_fwd     <= w_i_dout;
        r_w_fwd_vld <= 1'b1;
        r_i_fwd_vld <= 1'b1;
      end else begin
        if (W_DataOutRdy) r_w_fwd_vld <= 1'b0;
        if (I_DataOutRdy) r_i_fwd_vld <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      r_pipe_vld <= '0;
      for (int i = 0; i < MacLatency; i++) r_pipe_data[i] <= '0;
    end else if (clk_en) begin
      r_pipe_vld[0]  <= w_fire;
      r_pipe_data[0] <= w_stage0;
      for (int i = 1; i < MacLatency; i++) begin
        r_pipe_vld[i]  <= r_pipe_vld[i-1];
        r_pipe_data[i] <= r_pipe_data[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      r_inflight <= '0;
    end else if (clk_en) begin
      r_inflight <= r_inflight + FlyW'(w_fire) - FlyW'(w_exit);
    end
  end

  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      r_acc    <= '0;
      r_lcount <= '0;
    end else if (w_exit && (r_mode == PE_MODE_LOCAL)) begin
      if (w_last) begin
        r_acc    <= '0;
        r_lcount <= '0;
      end else begin
        r_acc    <= w_acc_sum;
        r_lcount <= r_lcount + AccLenWidth'(1);
      end
    end
  end

endmodule
